// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/decode boundary: instruction layout, opcodes, fetch FSM states.
// Opcodes 7 (BT) and 8 (BF) branch, 15 (HALT) stops; all others pass straight through to the decoder.
package isa_pkg;

  localparam int INST_W   = 9;
  localparam int TYPE_BIT = 8;
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 4;
  localparam int REG_MSB  = 3;
  localparam int REG_LSB  = 0;
  localparam int OPND_MSB = 7;

  localparam logic [INST_W-1:0] HALT_WORD = 9'h1F0;

  typedef enum logic [3:0] {
    OP_GET  = 4'd0,
    OP_PUT  = 4'd1,
    OP_ADD  = 4'd2,
    OP_SUB  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_BT   = 4'd7,
    OP_BF   = 4'd8,
    OP_LD   = 4'd9,
    OP_ST   = 4'd10,
    OP_SHL  = 4'd11,
    OP_SHR  = 4'd12,
    OP_NOT  = 4'd13,
    OP_CLR  = 4'd14,
    OP_HALT = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } fetch_state_e;

  // Control opcodes only exist for register-type words; TypeBit=0 bits[7:4] are immediate data.
  function automatic logic is_ctrl(input logic [INST_W-1:0] word, input opcode_e op);
    return word[TYPE_BIT] && (word[OP_MSB:OP_LSB] == op);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle between instruction fetch, instruction ROM and the control decoder.
// InstValid qualifies TypeBit/OP/Operand for the current cycle; the decoder always accepts (no ready).
interface instr_fetch_if #(
  parameter int PC_W = 10
) ();

  logic [PC_W-1:0]           InstAddr;
  logic [isa_pkg::INST_W-1:0] InstData;
  logic                      TypeBit;
  logic [3:0]                OP;
  logic [7:0]                Operand;
  logic                      InstValid;

  modport master (
    output InstAddr,
    input  InstData,
    output TypeBit,
    output OP,
    output Operand,
    output InstValid
  );

  modport slave (
    input  InstAddr,
    output InstData,
    input  TypeBit,
    input  OP,
    input  Operand,
    input  InstValid
  );

endinterface

// File: rtl/instr_fetch_branch_lut.sv
// branch_lut: 16-entry branch target table, one write port and one asynchronous read port.
// Compiled only when BRANCH_LUT_EN is defined; a same-cycle write is seen by the read one cycle later.
`ifdef BRANCH_LUT_EN
module branch_lut #(
  parameter int PC_W = 10
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_we,
  input  logic [3:0]      i_waddr,
  input  logic [PC_W-1:0] i_wdata,
  input  logic [3:0]      i_raddr,
  output logic [PC_W-1:0] o_rdata
);

  logic [PC_W-1:0] r_tbl [16];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 16; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (i_we) begin
      r_tbl[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_tbl[i_raddr];

endmodule
`endif

// File: rtl/instr_fetch.sv
// instr_fetch: PC/IR/FSM for the instruction-issue side of the decoder, one word issued per cycle.
// BRANCH_LUT_EN selects table-based branch targets; otherwise targets are PC-relative (sign-extended Reg).
module instr_fetch
  import isa_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  instr_fetch_if.master        fetch_bus,
  input  logic                 AccFlag,
  input  logic                 LutWe,
  input  logic [3:0]           LutAddr,
  input  logic [PC_W-1:0]      LutData,
  output logic                 Done,
  output fetch_state_e         o_dbg_state
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  fetch_state_e        r_state;
  logic [PC_W-1:0]     r_pc;
  logic [INST_W-1:0]   r_ir;
  logic                r_valid;

  fetch_state_e        w_state_nxt;
  logic [PC_W-1:0]     w_pc_nxt;
  logic [INST_W-1:0]   w_ir_nxt;
  logic                w_valid_nxt;

  logic                w_issue;
  logic                w_halt;
  logic                w_taken;
  logic [PC_W-1:0]     w_target;

`ifdef BRANCH_LUT_EN
  logic [PC_W-1:0] w_lut_target;

  branch_lut #(
    .PC_W (PC_W)
  ) u_branch_lut (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_we    (LutWe),
    .i_waddr (LutAddr),
    .i_wdata (LutData),
    .i_raddr (r_ir[REG_MSB:REG_LSB]),
    .o_rdata (w_lut_target)
  );

  assign w_target = w_lut_target;
`else
  logic [PC_W-1:0] w_rel;
  logic            w_unused_lut;

  // PC already points one past the issued word, so the branch's own address is PC-1.
  assign w_rel        = PC_W'($signed(r_ir[REG_MSB:REG_LSB]));
  assign w_target     = r_pc - PC_ONE + w_rel;
  assign w_unused_lut = ^{LutWe, LutAddr, LutData};
`endif

  // A word only counts as issued while RUN and IR holds a real instruction.
  assign w_issue = (r_state == S_RUN) && r_valid;
  assign w_halt  = w_issue && is_ctrl(r_ir, OP_HALT);
  assign w_taken = w_issue && ((is_ctrl(r_ir, OP_BT) &&  AccFlag) ||
                               (is_ctrl(r_ir, OP_BF) && !AccFlag));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= HALT_WORD;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_valid_nxt = r_valid;
    unique case (r_state)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = '0;
          w_valid_nxt = 1'b0;
        end
      end
      S_RUN: begin
        if (w_halt) begin
          w_state_nxt = S_HALTED;
          w_valid_nxt = 1'b0;
        end else if (w_taken) begin
          // Drop the word fetched behind the branch; the target is fetched next cycle.
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
        end else begin
          w_ir_nxt    = fetch_bus.InstData;
          w_pc_nxt    = r_pc + PC_ONE;
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign fetch_bus.InstAddr  = r_pc;
  assign fetch_bus.TypeBit   = r_ir[TYPE_BIT];
  assign fetch_bus.OP        = r_ir[OP_MSB:OP_LSB];
  assign fetch_bus.Operand   = r_ir[OPND_MSB:0];
  assign fetch_bus.InstValid = r_valid;

  assign Done        = (r_state == S_HALTED);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: an ISA-level program interpreter predicts the issued (address, word) stream,
// a negedge monitor pops and compares every issued word; directed programs plus random ROM images.
module tb_instr_fetch;
  import isa_pkg::*;

  localparam int PC_W  = 10;
  localparam int ROM_N = 1 << PC_W;
  localparam logic [8:0] HALT_W = 9'h1F0;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start;
  logic            AccFlag;
  logic            LutWe;
  logic [3:0]      LutAddr;
  logic [PC_W-1:0] LutData;
  logic            Done;
  fetch_state_e    dbg_state;

  instr_fetch_if #(.PC_W(PC_W)) bus_if ();

  logic [8:0]       rom [ROM_N];
  logic [PC_W-1:0]  tbl [16];
  logic [PC_W+8:0]  exp_q [$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  assign bus_if.InstData = rom[bus_if.InstAddr];

  instr_fetch #(.PC_W(PC_W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .fetch_bus   (bus_if),
    .AccFlag     (AccFlag),
    .LutWe       (LutWe),
    .LutAddr     (LutAddr),
    .LutData     (LutData),
    .Done        (Done),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int target_of(input int pc, input logic [8:0] w);
`ifdef BRANCH_LUT_EN
    return int'(tbl[w[3:0]]);
`else
    int off;
    off = w[3] ? int'(w[3:0]) - 16 : int'(w[3:0]);
    return (pc + off + ROM_N) % ROM_N;
`endif
  endfunction

  // Interprets the ROM from address 0; pushes every issued word and predicts cycles to Done.
  task automatic model(input bit acc, input int max_issue, output bit halted,
                       output int cycles, output logic [PC_W-1:0] end_pc);
    int pc;
    logic [8:0] w;
    pc = 0;
    halted = 1'b0;
    cycles = 1;
    end_pc = '0;
    for (int n = 0; n < max_issue; n++) begin
      w = rom[pc];
      exp_q.push_back({PC_W'(pc), w});
      cycles++;
      end_pc = PC_W'((pc + 1) % ROM_N);
      if (w[8] && w[7:4] == 4'd15) begin
        halted = 1'b1;
        cycles++;
        break;
      end
      if (w[8] && ((w[7:4] == 4'd7 && acc) || (w[7:4] == 4'd8 && !acc))) begin
        pc = target_of(pc, w);
        cycles++;
      end else begin
        pc = (pc + 1) % ROM_N;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin : monitor
    logic [PC_W-1:0] a;
    logic [8:0]      word;
    logic [PC_W+8:0] e;
    if (Reset !== 1'b1 && bus_if.InstValid === 1'b1) begin
      a    = bus_if.InstAddr - 1'b1;
      word = {bus_if.TypeBit, bus_if.OP, bus_if.Operand[3:0]};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL issue_extra: got addr %0d word %03h, expected no issue", a, word);
      end else begin
        e = exp_q.pop_front();
        check("issue", {a, word}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Reset = 1'b1;
    #1;
    check("rst_pc", bus_if.InstAddr, 0);
    check("rst_valid", bus_if.InstValid, 0);
    check("rst_done", Done, 0);
    check("rst_ir", {bus_if.TypeBit, bus_if.OP, bus_if.Operand[3:0]}, HALT_W);
    check("rst_state", dbg_state, S_IDLE);
    exp_q.delete();
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic write_tbl(input logic [3:0] idx, input logic [PC_W-1:0] data);
    LutWe   = 1'b1;
    LutAddr = idx;
    LutData = data;
    @(posedge Clk);
    #1;
    LutWe = 1'b0;
    tbl[idx] = data;
  endtask

  // Runs one program; a non-halting run is cut by Reset once max_issue words have issued.
  task automatic run_prog(input bit acc, input int max_issue, input int glitch_at,
                          input int poke_at, input logic [3:0] poke_addr,
                          input logic [PC_W-1:0] poke_data);
    bit halted;
    bit stopped;
    int cyc;
    int n;
    int budget;
    logic [PC_W-1:0] end_pc;
    AccFlag = acc;
    model(acc, max_issue, halted, cyc, end_pc);
    budget = cyc + 2 * max_issue + 20;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    n = 1;
    stopped = 1'b0;
    while (!stopped && n < budget) begin
      Start   = (n == glitch_at);
      LutWe   = (n == poke_at);
      LutAddr = poke_addr;
      LutData = poke_data;
      @(posedge Clk);
      #1;
      n++;
      if (halted && Done === 1'b1) begin
        stopped = 1'b1;
      end else begin
        @(negedge Clk);
        #1;
        if (!halted && exp_q.size() == 0) stopped = 1'b1;
      end
    end
    Start = 1'b0;
    LutWe = 1'b0;
    if (poke_at > 0) tbl[poke_addr] = poke_data;
    if (!stopped) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: got %0d words pending after %0d cycles, expected 0", exp_q.size(), n);
      do_reset();
    end else if (halted) begin
      check("done_cycle", n, cyc);
      check("halt_pc", bus_if.InstAddr, end_pc);
      check("halt_valid", bus_if.InstValid, 0);
      check("halt_state", dbg_state, S_HALTED);
      check("queue_drained", exp_q.size(), 0);
      repeat (2) @(posedge Clk);
      #1;
      check("pc_frozen", bus_if.InstAddr, end_pc);
      check("done_held", Done, 1);
    end else begin
      check("stop_pc", bus_if.InstAddr, end_pc);
      check("not_done", Done, 0);
      do_reset();
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < ROM_N; i++) rom[i] = HALT_W;
  endtask

  function automatic logic [8:0] rand_word();
    int r;
    int op;
    r = $urandom_range(0, 9);
    op = $urandom_range(0, 12);
    if (op >= 7) op += 2;
    case (r)
      0, 1, 2, 3: return {1'b0, 8'($urandom_range(0, 255))};
      4, 5:       return {1'b1, 4'(op), 4'($urandom_range(0, 15))};
      6:          return {1'b1, 4'd7, 4'($urandom_range(0, 15))};
      7:          return {1'b1, 4'd8, 4'($urandom_range(0, 15))};
      8:          return HALT_W;
      default:    return {1'b0, ($urandom_range(0, 1) != 0) ? 4'd15 : 4'd7, 4'($urandom_range(0, 15))};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    Reset   = 1'b1;
    Start   = 1'b0;
    AccFlag = 1'b0;
    LutWe   = 1'b0;
    LutAddr = '0;
    LutData = '0;
    clear_rom();
    do_reset();

    // geti 5 then halt
    rom[0] = 9'h005;
    rom[1] = HALT_W;
    run_prog(1'b0, 50, 0, 0, 4'd0, '0);

    // bt r3 taken / not taken, bf r3 taken
    clear_rom();
    rom[0]  = 9'h173;
    rom[1]  = 9'h005;
    rom[2]  = 9'h0A5;
    rom[20] = 9'h011;
    rom[21] = 9'h022;
    write_tbl(4'd3, PC_W'(20));
    run_prog(1'b1, 50, 0, 0, 4'd0, '0);
    run_prog(1'b0, 50, 0, 0, 4'd0, '0);
    rom[0] = 9'h183;
    run_prog(1'b0, 50, 0, 0, 4'd0, '0);

    // table write colliding with the branch read: old target used, new one seen next run
    rom[0]  = 9'h173;
    rom[40] = 9'h033;
    run_prog(1'b1, 50, 0, 2, 4'd3, PC_W'(40));
    run_prog(1'b1, 50, 0, 0, 4'd0, '0);

    // Start while running is ignored; reset mid-run at PC=7, then restart from 0
    clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = {1'b0, 8'(i * 3)};
    rom[10] = HALT_W;
    run_prog(1'b0, 7, 4, 0, 4'd0, '0);
    run_prog(1'b0, 50, 3, 0, 4'd0, '0);

    // immediate words that look like halt/bt; restart from HALTED
    clear_rom();
    rom[0] = 9'h0F0;
    rom[1] = 9'h070;
    rom[2] = 9'h080;
    run_prog(1'b1, 50, 0, 0, 4'd0, '0);
    run_prog(1'b0, 50, 0, 0, 4'd0, '0);

    // bt with Reg=-2 at address 5: loops 3..5 (relative) or jumps via table[14]
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = {1'b0, 8'(i + 1)};
    rom[5] = 9'h17E;
    write_tbl(4'd14, PC_W'(30));
    run_prog(1'b1, 20, 0, 0, 4'd0, '0);

    // straight-line code across the PC wrap
    for (int i = 0; i < ROM_N; i++) rom[i] = {1'b0, 8'($urandom_range(0, 255))};
    run_prog(1'b0, ROM_N + 6, 0, 0, 4'd0, '0);

    // random programs
    for (int p = 0; p < 15; p++) begin
      clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = rand_word();
      for (int i = 0; i < 16; i++) write_tbl(4'(i), PC_W'($urandom_range(0, 63)));
      run_prog(($urandom_range(0, 1) != 0), 120, 0, 0, 4'd0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
